half_adder_2: RTL and testbench
===============================

// Module: half_adder_2
// PURPOSE
//  - 1-bit half adder: sum = s XOR c_in, c_out = s AND c_in.
//  - Combinational result outputs have zero latency.
//  - Adds a registered copy of the result, plus a saturating carry-event counter.
//  - Leaf arithmetic cell; feeds ripple/full-adder chains and status logic.
// PARAMETERS
//  CNT_W   8   width of the carry-event counter (>=2)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       reset; asynchronous, active-high
//  s            in   1       addend A
//  c_in         in   1       addend B / carry in
//  in_valid     in   1       qualifies s/c_in for registered path and counter
//  clr_count    in   1       synchronous clear of carry_count
//  sum          out  1       combinational s^c_in
//  c_out        out  1       combinational s&c_in
//  sum_q        out  1       registered sum
//  c_out_q      out  1       registered carry
//  out_valid    out  1       registered in_valid
//  carry_count  out  CNT_W   number of valid cycles with c_out=1, saturating
// BEHAVIOUR
//  - Interface: one clock, asynchronous active-high reset.
//  - Combinational path (sum, c_out):
//    - Pure function of s and c_in; ignores clk, rst and in_valid.
//    - Updates in the same delta as its inputs.
//  - Truth table, s c_in -> sum c_out: 00->00, 01->10, 10->10, 11->01.
//  - Reset (rst=1, any time, independent of clk):
//    - sum_q, c_out_q and out_valid go to 0.
//    - carry_count goes to 0.
//    - Registered outputs stay at these values while rst is held.
//  - Registered path, at each posedge clk with rst=0:
//    - out_valid <= in_valid.
//    - If in_valid=1: sum_q <= sum and c_out_q <= c_out.
//    - If in_valid=0: sum_q and c_out_q hold their values.
//    - Latency is 1 cycle. No backpressure: output is accepted unconditionally.
//  - Counter, at posedge clk with rst=0, in this priority order:
//    - clr_count=1 -> carry_count <= 0. Clear wins over a simultaneous increment.
//    - Else if in_valid & c_out and carry_count != all-ones -> increment by 1.
//    - Else hold. At all-ones the counter saturates and does not wrap.
//  - X on s or c_in gives X on sum/c_out. No other outputs depend on X when in_valid=0.
// STRUCTURE
//  - Sub-module half_adder_core (s, c_in -> sum, c_out, combinational).
//    - Instantiated once.
//    - Its outputs drive the sum/c_out ports and the registers.
//  - No shared-package typedefs are needed.
//  - The counter saturation value is a localparam {CNT_W{1'b1}}.
// TESTING
//  - s=0,c_in=0 at t=0 -> sum=0, c_out=0 immediately.
//    - t=10: s=1 -> sum=1, c_out=0 with no clock edge needed.
//    - t=30: c_in=1 -> sum=0, c_out=1.
//  - Exhaustive: all four input pairs with in_valid=1, one per clock.
//    - sum_q/c_out_q equal the truth-table values one cycle later.
//    - out_valid=1 on each of those cycles.
//  - rst pulsed mid-cycle (between clock edges):
//    - sum_q, c_out_q, out_valid and carry_count read 0 before the next edge.
//    - sum/c_out still follow the inputs.
//  - CNT_W=2, s=c_in=1, in_valid=1 for 5 cycles:
//    - carry_count sequence is 1,2,3,3,3 (saturates).
//  - carry_count=2 with clr_count=1 and a carry event in the same cycle:
//    - carry_count=0 next cycle.
//  - in_valid=0 with s=c_in=1:
//    - sum_q/c_out_q hold, out_valid=0, carry_count unchanged.
//    - c_out=1 combinationally.

Source files
------------

// File: rtl/half_adder_2_pkg.sv
// rtl/half_adder_2_pkg.sv - shared constants for the registered half adder
package half_adder_2_pkg;

    localparam int CNT_W_DEFAULT = 8;

endpackage

// File: rtl/half_adder_2_core.sv
// rtl/half_adder_2_core.sv - purely combinational 1-bit half adder cell
module half_adder_core (
    input  logic s,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = s ^ c_in;
    assign c_out = s & c_in;

endmodule

// File: rtl/half_adder_2.sv
// rtl/half_adder_2.sv - half adder with registered result and saturating carry-event counter
module half_adder_2
    import half_adder_2_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s,
    input  logic             c_in,
    input  logic             in_valid,
    input  logic             clr_count,
    output logic             sum,
    output logic             c_out,
    output logic             sum_q,
    output logic             c_out_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             core_sum;
    logic             core_cout;
    logic             res_sum_q,  res_sum_d;
    logic             res_cout_q, res_cout_d;
    logic             valid_q,    valid_d;
    logic [CNT_W-1:0] count_q,    count_d;

    half_adder_core u_core (
        .s     (s),
        .c_in  (c_in),
        .sum   (core_sum),
        .c_out (core_cout)
    );

    // Gating on in_valid first keeps X on idle data out of the registers.
    always_comb begin
        res_sum_d  = res_sum_q;
        res_cout_d = res_cout_q;
        valid_d    = in_valid;
        count_d    = count_q;
        if (in_valid) begin
            res_sum_d  = core_sum;
            res_cout_d = core_cout;
        end
        if (clr_count) begin
            count_d = '0;
        end else if (in_valid && core_cout && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_sum_q  <= 1'b0;
            res_cout_q <= 1'b0;
            valid_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            res_sum_q  <= res_sum_d;
            res_cout_q <= res_cout_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
        end
    end

    assign sum         = core_sum;
    assign c_out       = core_cout;
    assign sum_q       = res_sum_q;
    assign c_out_q     = res_cout_q;
    assign out_valid   = valid_q;
    assign carry_count = count_q;

endmodule

// File: tb/tb_half_adder_2.sv
// tb/tb_half_adder_2.sv - scoreboard bench for half_adder_2 with a 2-bit counter
module tb_half_adder_2;

    localparam int TW = 2;

    typedef struct packed {
        logic          sum;
        logic          cout;
        logic [TW-1:0] cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s = 1'b0;
    logic          c_in = 1'b0;
    logic          in_valid = 1'b0;
    logic          clr_count = 1'b0;
    logic          sum, c_out, sum_q, c_out_q, out_valid;
    logic [TW-1:0] carry_count;

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    int   exp_cnt = 0;

    half_adder_2 #(.CNT_W(TW)) dut (
        .clk         (clk),
        .rst         (rst),
        .s           (s),
        .c_in        (c_in),
        .in_valid    (in_valid),
        .clr_count   (clr_count),
        .sum         (sum),
        .c_out       (c_out),
        .sum_q       (sum_q),
        .c_out_q     (c_out_q),
        .out_valid   (out_valid),
        .carry_count (carry_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle of stimulus; valid cycles push the expected registered result.
    task automatic cyc(input logic iv, input logic a, input logic b, input logic clr);
        exp_t e;
        @(negedge clk);
        s = a; c_in = b; in_valid = iv; clr_count = clr;
        if (clr) exp_cnt = 0;
        else if (iv && a && b && exp_cnt != 3) exp_cnt++;
        if (iv) begin
            e.sum  = a ^ b;
            e.cout = a & b;
            e.cnt  = exp_cnt[TW-1:0];
            sb_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("mon_sum_q", {31'b0, sum_q}, {31'b0, e.sum});
                chk("mon_c_out_q", {31'b0, c_out_q}, {31'b0, e.cout});
                chk("mon_carry_count", {30'b0, carry_count}, {30'b0, e.cnt});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        chk("t0_sum", {31'b0, sum}, 0);
        chk("t0_c_out", {31'b0, c_out}, 0);
        chk("rst_sum_q", {31'b0, sum_q}, 0);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_count", {30'b0, carry_count}, 0);
        #9 s = 1'b1;
        #1;
        chk("t10_sum", {31'b0, sum}, 1);
        chk("t10_c_out", {31'b0, c_out}, 0);
        #19 c_in = 1'b1;
        #1;
        chk("t30_sum", {31'b0, sum}, 0);
        chk("t30_c_out", {31'b0, c_out}, 1);
        chk("rst_held_c_out_q", {31'b0, c_out_q}, 0);
        @(negedge clk);
        s = 1'b0; c_in = 1'b0; rst = 1'b0;

        // exhaustive truth table through the registered path
        cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 1, 1, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        // asynchronous reset between edges
        @(posedge clk);
        #2 rst = 1'b1; s = 1'b1; c_in = 1'b0;
        #1;
        chk("arst_sum_q", {31'b0, sum_q}, 0);
        chk("arst_c_out_q", {31'b0, c_out_q}, 0);
        chk("arst_out_valid", {31'b0, out_valid}, 0);
        chk("arst_count", {30'b0, carry_count}, 0);
        chk("arst_comb_sum", {31'b0, sum}, 1);
        chk("arst_comb_c_out", {31'b0, c_out}, 0);
        #1 rst = 1'b0;
        exp_cnt = 0;

        // saturation: 1,2,3,3,3
        repeat (5) cyc(1, 1, 1, 0);

        // clear alone, then clear beating a simultaneous carry event at count 2
        cyc(0, 0, 0, 1);
        @(posedge clk); #1;
        chk("clr_only_count", {30'b0, carry_count}, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 1, 1, 0);
        cyc(1, 1, 1, 1);

        // hold with in_valid=0 and s=c_in=1
        cyc(1, 1, 0, 0);
        cyc(0, 1, 1, 0);
        @(posedge clk); #1;
        chk("hold_sum_q", {31'b0, sum_q}, 1);
        chk("hold_c_out_q", {31'b0, c_out_q}, 0);
        chk("hold_out_valid", {31'b0, out_valid}, 0);
        chk("hold_count", {30'b0, carry_count}, exp_cnt);
        chk("hold_comb_c_out", {31'b0, c_out}, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        @(negedge clk); #1;
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
